// File: rtl/reg_file_sb_if.sv
// Bundled read/write-back/issue signals of the scoreboarded register file.
// master drives the requests, slave is the register file itself.
interface reg_file_sb_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS)
);
  logic [AW-1:0]          A1, A2;
  logic [XLEN-1:0]        RD1, RD2;
  logic                   HZ1, HZ2;
  logic                   WEA, WEB;
  logic [AW-1:0]          WAA, WAB;
  logic [XLEN-1:0]        WDA, WDB;
  logic                   ISS;
  logic [AW-1:0]          ISS_RD;
  logic [$clog2(NREGS):0] BUSY_CNT;

  modport master (
    output A1, A2, WEA, WAA, WDA, WEB, WAB, WDB, ISS, ISS_RD,
    input  RD1, RD2, HZ1, HZ2, BUSY_CNT
  );
  modport slave (
    input  A1, A2, WEA, WAA, WDA, WEB, WAB, WDB, ISS, ISS_RD,
    output RD1, RD2, HZ1, HZ2, BUSY_CNT
  );
endinterface

// File: rtl/reg_file_sb.sv
// Integer register file: 2 combinational read ports, ALU/MEM write-back ports,
// optional write-to-read bypass and a busy scoreboard with RAW hazard flags.
module reg_file_sb #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int AW     = $clog2(NREGS),
  parameter int BYPASS = 1
) (
  input  logic         clk,
  input  logic         rst,
  reg_file_sb_if.slave bus
);
  localparam int CW = $clog2(NREGS) + 1;

  logic [NREGS-1:0][XLEN-1:0] mem_q;
  logic [NREGS-1:0]           busy_q, busy_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic                       wa_ok, wb_ok, iss_ok;

  logic [1:0][AW-1:0]   ra;
  logic [1:0][XLEN-1:0] rd;
  logic [1:0]           hz, byp;

  // Writes and issues to x0 are dropped here, so x0 stays zero and never busy.
  assign wa_ok  = bus.WEA && (bus.WAA != '0);
  assign wb_ok  = bus.WEB && (bus.WAB != '0);
  assign iss_ok = bus.ISS && (bus.ISS_RD != '0);

  always_comb begin
    busy_d = busy_q;
    if (wa_ok)  busy_d[bus.WAA]    = 1'b0;
    if (wb_ok)  busy_d[bus.WAB]    = 1'b0;
    if (iss_ok) busy_d[bus.ISS_RD] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Counter tracks 0->1 and 1->0 edges of the busy vector, so it equals popcount.
  always_comb begin
    cnt_d = cnt_q;
    for (int i = 1; i < NREGS; i++) begin
      if (busy_d[i] && !busy_q[i])      cnt_d = cnt_d + CW'(1);
      else if (!busy_d[i] && busy_q[i]) cnt_d = cnt_d - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q  <= '0;
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (wa_ok) mem_q[bus.WAA] <= bus.WDA;
      if (wb_ok) mem_q[bus.WAB] <= bus.WDB;  // port B wins on a conflict
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign ra = {bus.A2, bus.A1};

  always_comb begin
    rd  = '0;
    hz  = '0;
    byp = '0;
    for (int p = 0; p < 2; p++) begin
      rd[p] = mem_q[ra[p]];
      if (BYPASS != 0) begin
        if (wa_ok && (bus.WAA == ra[p])) begin
          rd[p]  = bus.WDA;
          byp[p] = 1'b1;
        end
        if (wb_ok && (bus.WAB == ra[p])) begin
          rd[p]  = bus.WDB;
          byp[p] = 1'b1;
        end
      end
      hz[p] = busy_q[ra[p]] && !byp[p];
    end
  end

  assign bus.RD1      = rd[0];
  assign bus.RD2      = rd[1];
  assign bus.HZ1      = hz[0];
  assign bus.HZ2      = hz[1];
  assign bus.BUSY_CNT = cnt_q;
endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised successor to the integer register file for the pipelined core. It provides two combinational read ports and two synchronous write-back ports (ALU and load/MEM), with an optional same-cycle write-to-read bypass. A per-register busy scoreboard tracks outstanding destination writes, and the block reports RAW hazards on each read port for the hazard unit.

## Interface
Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of architectural registers; power of two, at least 4.
- AW, $clog2(NREGS), register address width.
- BYPASS, 1: 1 = a read of an address being written this cycle returns the write data; 0 = returns the stored value.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- A1, A2  in  AW  read addresses.
- RD1, RD2  out  XLEN  read data; 0 when the address is 0.
- HZ1, HZ2  out  1  RAW hazard: the addressed register is busy after bypass.
- WEA, WAA[AW], WDA[XLEN]  in  write port A (ALU write-back).
- WEB, WAB[AW], WDB[XLEN]  in  write port B (load write-back).
- ISS  in  1  issue strobe: marks ISS_RD busy.
- ISS_RD  in  AW  destination of the issuing instruction.
- BUSY_CNT  out  $clog2(NREGS)+1  registered count of busy registers.

## Operation
- Storage: NREGS x XLEN array plus an NREGS-bit busy vector. Register 0 is hardwired to 0 and is never busy. Writes and issues to address 0 are ignored and do not change BUSY_CNT.
- Write: on a clock edge, each write port with its enable set and a nonzero address updates its register.
- Write conflict: if WEA and WEB target the same nonzero address, port B wins and port A's data is dropped.
- Busy clear: any enabled write to a nonzero address clears busy for that address.
- Busy set: ISS with a nonzero ISS_RD sets busy for ISS_RD.
- Set and clear on the same address in the same cycle: set wins, so the register ends the cycle busy.
- Issue to an already-busy register keeps it busy. Only one write is tracked per register; the issuing stage must not issue a WAW while the destination is busy.
- BUSY_CNT is a registered counter updated each edge by the number of 0->1 transitions minus the number of 1->0 transitions. It always equals the popcount of the busy vector.
- Read, BYPASS=1: on an address match with port B, return WDB. Otherwise, on a match with port A, return WDA. Otherwise return the array value. Only nonzero, enabled writes participate.
- Read, BYPASS=0: always return the array value.
- HZx = busy[Ax] AND NOT(BYPASS AND a same-cycle write to Ax). HZx is 0 for Ax = 0.

## Timing
- Reads (RDx, HZx) are combinational from addresses, array state and, with BYPASS=1, the current write ports.
- Write latency: with BYPASS=0, data is visible on RDx the cycle after the write edge. With BYPASS=1, it is visible in the same cycle.
- Busy latency: a register is busy from the edge on which ISS is sampled. HZx asserts in the following cycle.
- Reset (rst=0, asynchronous):
  - All registers and busy bits clear and BUSY_CNT = 0 immediately, independent of clk.
  - RD1/RD2 = 0 and HZ1/HZ2 = 0, except that with BYPASS=1 an enabled write during reset still shows its data through the bypass path.
  - Writes and issues presented while rst=0 are ignored.
- Reset deasserted mid-operation: the first edge with rst=1 accepts writes and issues normally.
- BUSY_CNT saturation cannot occur: its maximum is NREGS-1, which fits the width.

## Test plan
- Reset/x0: pulse rst low between edges -> RD1=RD2=0 and BUSY_CNT=0 at once. Write 0xDEADBEEF to address 0 -> reading address 0 returns 0.
- Dual write and conflict: WEA to r5=0x11 and WEB to r6=0x22 -> both read back. Next cycle, WEA and WEB both to r7 (0xAA and 0xBB) -> r7 reads 0xBB.
- Bypass (BYPASS=1): A1=r9 while WEB writes r9=0x1234 -> RD1=0x1234 in the same cycle. With BYPASS=0 -> RD1 returns the old value, then 0x1234 the next cycle.
- Scoreboard: ISS on r3 -> HZ1=1 for A1=r3 and BUSY_CNT=1. WEB to r3 -> with BYPASS=1, HZ1=0 in that cycle. After the edge, BUSY_CNT=0.
- Simultaneous set/clear: r4 busy; ISS r4 together with WEA r4 -> r4 still busy and BUSY_CNT unchanged. Random issue/write mix over 10k cycles -> BUSY_CNT always equals popcount(busy).
- Mid-run reset: with 5 registers busy, assert rst -> BUSY_CNT=0 and all HZx=0 asynchronously, and all data reads 0.
